// File: rtl/msb_finder_pipe.sv
`timescale 1ns/1ps
// Two-stage pipelined locator of the highest (or lowest) set bit of a wide word.
// Stage 1 searches each SEG_W-bit segment; stage 2 picks the winning segment.
module msb_finder_pipe #(
   parameter  int DW_IN = 512,
   parameter  int SEG_W = 32,
   localparam int IDX_W = $clog2(DW_IN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW_IN-1:0] in_data,
   input  logic             in_lsb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_found,
   output logic             out_lsb
);
   localparam int NSEG  = DW_IN / SEG_W;
   localparam int LOC_W = $clog2(SEG_W);

   // Handshake: a word crosses a boundary on a rising edge where valid && ready.
   // A stage advances when its downstream slot is empty or is being emptied.
   logic             w_adv1;
   logic             w_adv2;
   logic [NSEG-1:0]  w_nz;
   logic [LOC_W-1:0] w_loc [NSEG];
   logic [IDX_W-1:0] w_idx;
   logic             w_found;

   logic             r_s1_valid;
   logic             r_s1_lsb;
   logic [NSEG-1:0]  r_s1_nz;
   logic [LOC_W-1:0] r_s1_loc [NSEG];

   logic             r_s2_valid;
   logic [IDX_W-1:0] r_s2_idx;
   logic             r_s2_found;
   logic             r_s2_lsb;

   assign w_adv2   = ~r_s2_valid | out_ready;
   assign w_adv1   = ~r_s1_valid | w_adv2;
   assign in_ready = w_adv1 & ~rst;

   // Per-segment search: ascending scan keeps the highest hit, descending the lowest.
   always_comb begin
      for (int s = 0; s < NSEG; s++) begin
         w_nz[s]  = |in_data[s*SEG_W +: SEG_W];
         w_loc[s] = '0;
         for (int b = 0; b < SEG_W; b++) begin
            if (in_data[s*SEG_W + b] && !in_lsb) w_loc[s] = LOC_W'(b);
         end
         for (int b = SEG_W - 1; b >= 0; b--) begin
            if (in_data[s*SEG_W + b] && in_lsb) w_loc[s] = LOC_W'(b);
         end
      end
   end

   // Segment base is a multiple of SEG_W, so OR-ing the local index is an exact add.
   always_comb begin
      w_idx = '0;
      for (int s = 0; s < NSEG; s++) begin
         if (r_s1_nz[s] && !r_s1_lsb) w_idx = IDX_W'(s*SEG_W) | IDX_W'(r_s1_loc[s]);
      end
      for (int s = NSEG - 1; s >= 0; s--) begin
         if (r_s1_nz[s] && r_s1_lsb) w_idx = IDX_W'(s*SEG_W) | IDX_W'(r_s1_loc[s]);
      end
   end

   assign w_found = |r_s1_nz;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_idx   <= '0;
         r_s2_found <= 1'b0;
         r_s2_lsb   <= 1'b0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= in_valid;
            r_s1_lsb   <= in_lsb;
            r_s1_nz    <= w_nz;
            r_s1_loc   <= w_loc;
         end
         if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            r_s2_idx   <= w_idx;
            r_s2_found <= w_found;
            r_s2_lsb   <= r_s1_lsb;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_idx   = r_s2_idx;
   assign out_found = r_s2_found;
   assign out_lsb   = r_s2_lsb;

endmodule

// File: tb/tb_msb_finder_pipe.sv
`timescale 1ns/1ps
// Bench for msb_finder_pipe: directed cases on the 512/32 instance, then random
// traffic on 64/8, 512/32 and 1024/64 instances against a bit-scan reference.
module tb_msb_finder_pipe;
   localparam int CFG_DW  [3] = '{64, 512, 1024};
   localparam int CFG_SEG [3] = '{8, 32, 64};
   localparam int N_RND = 3400;

   logic          clk;
   logic          rst;
   logic          go_rnd;
   logic          dir_valid;
   logic          dir_lsb;
   logic          dir_out_ready;
   logic [1023:0] dir_data;
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string nm, int tag, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [cfg %0d] got %0d expected %0d at cycle %0d", nm, tag, act, exp, cyc);
      end
   endtask

   // Reference: scan every bit; MSB keeps the last hit, LSB the first. -1 = none.
   function automatic int ref_idx(logic [1023:0] d, logic lsb);
      int r;
      r = -1;
      for (int i = 0; i < 1024; i++) begin
         if (d[i] && (!lsb || r < 0)) r = i;
      end
      return r;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int DW = CFG_DW[g];
      localparam int SW = CFG_SEG[g];
      localparam int IW = $clog2(DW);
      localparam int EW = IW + 2;

      logic          in_valid, in_ready, in_lsb;
      logic          out_valid, out_ready, out_found, out_lsb;
      logic [DW-1:0] in_data;
      logic [IW-1:0] out_idx;
      logic          rnd_valid, rnd_lsb, rnd_out_ready;
      logic [DW-1:0] rnd_data;
      logic          done;

      logic [EW-1:0] exp_q[$];
      int            acc_q[$];
      int            got_idx_q[$], got_found_q[$], got_lsb_q[$], got_lat_q[$], got_cyc_q[$];
      logic          prev_stall = 1'b0;
      logic [EW-1:0] held;

      assign in_valid  = go_rnd ? rnd_valid : ((g == 1) ? dir_valid : 1'b0);
      assign in_data   = go_rnd ? rnd_data : dir_data[DW-1:0];
      assign in_lsb    = go_rnd ? rnd_lsb : dir_lsb;
      assign out_ready = go_rnd ? rnd_out_ready : dir_out_ready;

      msb_finder_pipe #(.DW_IN(DW), .SEG_W(SW)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_data   (in_data),
         .in_lsb    (in_lsb),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_idx   (out_idx),
         .out_found (out_found),
         .out_lsb   (out_lsb)
      );

      // ---------------- scoreboard ----------------
      always @(negedge clk) begin : mon
         int            n, r;
         logic [EW-1:0] got, e;
         if (rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_stall = 1'b0;
         end else begin
            n   = exp_q.size();
            got = {out_lsb, out_found, out_idx};
            check("in_ready", g, in_ready, (n < 2) || out_ready);
            if (n == 0) check("out_valid_empty", g, out_valid, 0);
            if (n == 2) check("out_valid_full", g, out_valid, 1);
            if (prev_stall) begin
               check("stall_valid", g, out_valid, 1);
               check("stall_hold", g, got, held);
            end
            if (out_valid && out_ready) begin
               if (n == 0) begin
                  check("unexpected_out", g, out_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("result", g, got, e);
                  got_idx_q.push_back(int'(out_idx));
                  got_found_q.push_back(int'(out_found));
                  got_lsb_q.push_back(int'(out_lsb));
                  got_lat_q.push_back(cyc - acc_q.pop_front());
                  got_cyc_q.push_back(cyc);
               end
            end
            if (in_valid && in_ready) begin
               r = ref_idx(1024'(in_data), in_lsb);
               exp_q.push_back({in_lsb, 1'(r >= 0), IW'(r < 0 ? 0 : r)});
               acc_q.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            held       = got;
         end
      end

      // ---------------- random driver ----------------
      task automatic gen_word();
         int            kind, pos, lo;
         logic [DW-1:0] v;
         v    = '0;
         kind = int'($urandom_range(0, 4));
         case (kind)
            1: begin pos = int'($urandom_range(0, DW - 1)); v[pos] = 1'b1; end
            2: begin
               pos = int'($urandom_range(0, DW - 1)); v[pos] = 1'b1;
               pos = int'($urandom_range(0, DW - 1)); v[pos] = 1'b1;
            end
            3, 4: for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
            default: v = '0;
         endcase
         if (kind == 4) begin
            lo = int'($urandom_range(0, DW / SW - 1)) * SW;
            for (int i = 0; i < DW; i++) if (i < lo || i >= lo + SW) v[i] = 1'b0;
         end
         rnd_data = v;
         rnd_lsb  = 1'($urandom_range(0, 1));
      endtask

      initial begin : rnd_drv
         int sent, cycles;
         bit took;
         rnd_valid = 1'b0; rnd_lsb = 1'b0; rnd_out_ready = 1'b0; rnd_data = '0; done = 1'b0;
         wait (go_rnd == 1'b1);
         sent = 0; cycles = 0;
         while (sent < N_RND && cycles < 40000) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            cycles++;
            if (took) sent++;
            rnd_out_ready = ($urandom_range(0, 3) != 0);
            if (!rnd_valid || took) begin
               rnd_valid = (sent < N_RND) && ($urandom_range(0, 3) != 0);
               if (rnd_valid) gen_word();
            end
         end
         check("rnd_sent", g, sent, N_RND);
         rnd_valid = 1'b0; rnd_out_ready = 1'b1; cycles = 0;
         while (exp_q.size() != 0 && cycles < 100) begin
            @(posedge clk);
            cycles++;
         end
         #1;
         check("rnd_drain", g, exp_q.size(), 0);
         done = 1'b1;
      end
   end

   // ---------------- directed driver tasks (512/32 instance) ----------------
   task automatic send(input logic [511:0] d, input logic l);
      int t;
      bit took;
      dir_valid = 1'b1; dir_data = 1024'(d); dir_lsb = l; t = 0; took = 1'b0;
      while (!took && t < 50) begin
         @(negedge clk);
         took = g_cfg[1].in_ready;
         @(posedge clk); #1;
         t++;
      end
      dir_valid = 1'b0;
      check("send_accept", 1, took, 1);
   endtask

   task automatic wait_res(int target);
      int t;
      t = 0;
      while (g_cfg[1].got_idx_q.size() < target && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("result_count", 1, g_cfg[1].got_idx_q.size() >= target, 1);
   endtask

   task automatic exp_res(string nm, int k, int idx, int found, int lsb);
      check(nm, 1, g_cfg[1].got_idx_q[k], idx);
      check(nm, 1, g_cfg[1].got_found_q[k], found);
      check(nm, 1, g_cfg[1].got_lsb_q[k], lsb);
   endtask

   // ---------------- directed sequence, random phase, report ----------------
   initial begin : main
      logic [511:0] w;
      logic [511:0] ws [4];
      int  base, k, t;
      bit  took;
      rst = 1'b1; go_rnd = 1'b0;
      dir_valid = 1'b0; dir_lsb = 1'b0; dir_out_ready = 1'b0; dir_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 1, g_cfg[1].out_valid, 0);
      check("rst_out_idx",   1, g_cfg[1].out_idx, 0);
      check("rst_out_found", 1, g_cfg[1].out_found, 0);
      check("rst_out_lsb",   1, g_cfg[1].out_lsb, 0);
      check("rst_in_ready",  1, g_cfg[1].in_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", 1, g_cfg[1].in_ready, 1);
      @(posedge clk); #1;

      // MSB stream: one result per cycle, 2 cycles after the accept cycle
      dir_out_ready = 1'b1;
      base = g_cfg[1].got_idx_q.size();
      send(512'h123, 1'b0); send(512'h456, 1'b0); send(512'h789, 1'b0);
      wait_res(base + 3);
      exp_res("t1_w0", base, 8, 1, 0);
      exp_res("t1_w1", base + 1, 10, 1, 0);
      exp_res("t1_w2", base + 2, 10, 1, 0);
      for (int i = 0; i < 3; i++) check("t1_latency", 1, g_cfg[1].got_lat_q[base + i], 2);
      for (int i = 1; i < 3; i++)
         check("t1_rate", 1, g_cfg[1].got_cyc_q[base + i] - g_cfg[1].got_cyc_q[base + i - 1], 1);

      // LSB stream
      base = g_cfg[1].got_idx_q.size();
      send(512'h123, 1'b1); send(512'h456, 1'b1); send(512'h789, 1'b1);
      wait_res(base + 3);
      exp_res("t2_w0", base, 0, 1, 1);
      exp_res("t2_w1", base + 1, 1, 1, 1);
      exp_res("t2_w2", base + 2, 0, 1, 1);

      // Top bit, bottom bit, segment boundary, in both modes
      for (int m = 0; m < 2; m++) begin
         base = g_cfg[1].got_idx_q.size();
         w = '0; w[511] = 1'b1; send(w, 1'(m));
         w = '0; w[0] = 1'b1;   send(w, 1'(m));
         w = '0; w[31] = 1'b1; w[32] = 1'b1; send(w, 1'(m));
         wait_res(base + 3);
         exp_res("t3_bit511", base, 511, 1, m);
         exp_res("t3_bit0", base + 1, 0, 1, m);
         exp_res("t3_boundary", base + 2, (m == 1) ? 31 : 32, 1, m);
      end

      // Zero word is still delivered
      base = g_cfg[1].got_idx_q.size();
      send('0, 1'b0); send('0, 1'b1);
      wait_res(base + 2);
      exp_res("t4_zero_msb", base, 0, 0, 0);
      exp_res("t4_zero_lsb", base + 1, 0, 0, 1);

      // Stall: 4 words offered over 5 cycles with the consumer blocked
      ws[0] = '0; ws[0][5] = 1'b1;
      ws[1] = '0; ws[1][100] = 1'b1;
      ws[2] = '0; ws[2][300] = 1'b1;
      ws[3] = '0; ws[3][511] = 1'b1;
      base = g_cfg[1].got_idx_q.size();
      dir_out_ready = 1'b0; dir_valid = 1'b1; dir_lsb = 1'b0; k = 0;
      repeat (5) begin
         dir_data = 1024'(ws[k]);
         @(negedge clk);
         took = g_cfg[1].in_ready;
         @(posedge clk); #1;
         if (took && k < 3) k++;
      end
      @(negedge clk);
      check("t5_accepted", 1, k, 2);
      check("t5_in_ready", 1, g_cfg[1].in_ready, 0);
      check("t5_out_valid", 1, g_cfg[1].out_valid, 1);
      check("t5_hold_idx", 1, g_cfg[1].out_idx, 5);
      @(posedge clk); #1;
      dir_out_ready = 1'b1; dir_valid = 1'b0;
      while (k < 4) begin
         send(ws[k], 1'b0);
         k++;
      end
      wait_res(base + 4);
      exp_res("t5_order0", base, 5, 1, 0);
      exp_res("t5_order1", base + 1, 100, 1, 0);
      exp_res("t5_order2", base + 2, 300, 1, 0);
      exp_res("t5_order3", base + 3, 511, 1, 0);
      repeat (4) @(posedge clk);
      #1;
      check("t5_no_dup", 1, g_cfg[1].got_idx_q.size(), base + 4);

      // Reset with two words in flight discards them
      base = g_cfg[1].got_idx_q.size();
      dir_out_ready = 1'b0;
      w = '0; w[40] = 1'b1; send(w, 1'b0);
      w = '0; w[41] = 1'b1; send(w, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t6_out_valid", 1, g_cfg[1].out_valid, 0);
      check("t6_out_found", 1, g_cfg[1].out_found, 0);
      check("t6_in_ready", 1, g_cfg[1].in_ready, 1);
      @(posedge clk); #1;
      dir_out_ready = 1'b1;
      w = '0; w[77] = 1'b1; send(w, 1'b0);
      wait_res(base + 1);
      exp_res("t6_first_after_rst", base, 77, 1, 0);
      repeat (4) @(posedge clk);
      #1;
      check("t6_discarded", 1, g_cfg[1].got_idx_q.size(), base + 1);

      // Random traffic on all three widths
      go_rnd = 1'b1;
      t = 0;
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && t < 50000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("rnd_done0", 0, g_cfg[0].done, 1);
      check("rnd_done1", 1, g_cfg[1].done, 1);
      check("rnd_done2", 2, g_cfg[2].done, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
